ifetch_unit: RTL and testbench

Instruction fetch front end for the single-cycle MIPS core; the read side of the 128-word instruction ROM. Holds the program counter and drives the ROM word address. Registers the returned word into a fetch register with a valid flag. Takes stall and redirect (branch/jump) requests from the core, and halts with a fault flag on an out-of-range or misaligned PC.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/ifetch_unit_if.sv | 33 +++
 rtl/pc_reg.sv | 59 +++++
 rtl/ifetch_unit.sv | 86 ++++++++
 tb/tb_ifetch_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the single-cycle MIPS core front end.
//   XLEN          - datapath width
//   IMEM_ADDR_W   - instruction ROM word-address width (128 words)
//   fetch_state_t - fetch FSM states
//   NOP           - instruction value used for an empty fetch register
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned IMEM_ADDR_W = 7;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  // True when a byte PC is not word aligned.
  function automatic logic pc_misaligned(logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: bundle between the fetch unit, the core and the instruction ROM.
//   Core -> fetch : stall, redirect_valid, redirect_pc
//   ROM  -> fetch : rom_data
//   Fetch -> ROM  : rom_addr
//   Fetch -> core : inst, inst_pc, inst_pc4, inst_valid, fault, fetch_cnt
// master is the fetch unit side, slave the core/ROM side.
interface ifetch_unit_if #(
  parameter int unsigned ADDR_W = cpu_pkg::IMEM_ADDR_W
);

  logic                      stall;
  logic                      redirect_valid;
  logic [cpu_pkg::XLEN-1:0]  redirect_pc;
  logic [ADDR_W-1:0]         rom_addr;
  logic [cpu_pkg::XLEN-1:0]  rom_data;
  logic [cpu_pkg::XLEN-1:0]  inst;
  logic [cpu_pkg::XLEN-1:0]  inst_pc;
  logic [cpu_pkg::XLEN-1:0]  inst_pc4;
  logic                      inst_valid;
  logic                      fault;
  logic [cpu_pkg::XLEN-1:0]  fetch_cnt;

  modport master (
    input  stall, redirect_valid, redirect_pc, rom_data,
    output rom_addr, inst, inst_pc, inst_pc4, inst_valid, fault, fetch_cnt
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, rom_data,
    input  rom_addr, inst, inst_pc, inst_pc4, inst_valid, fault, fetch_cnt
  );

endinterface

// File: rtl/pc_reg.sv
// pc_reg: program counter with next-PC selection and fetch fault detection.
//   clk, rst_n         - clock, asynchronous active-low reset
//   i_run              - fetch FSM is in RUN; PC freezes otherwise
//   i_stall            - hold the PC
//   i_redirect_valid   - load i_redirect_pc (wins over stall)
//   i_redirect_pc      - byte target PC
//   o_pc               - current byte PC
//   o_fault            - current PC is misaligned/out of range, or redirect target misaligned
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned     ROM_DEPTH = 77,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_run,
  input  logic            i_stall,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc,
  output logic            o_fault
);

  localparam logic [XLEN-1:0] DepthWords = XLEN'(ROM_DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            w_pc_bad;
  logic            w_redir_bad;

  // Full word index is checked so high address bits dropped from rom_addr still fault.
  assign w_pc_bad    = pc_misaligned(r_pc) || ({2'b00, r_pc[XLEN-1:2]} >= DepthWords);
  assign w_redir_bad = i_redirect_valid && pc_misaligned(i_redirect_pc);
  assign o_fault     = w_pc_bad || w_redir_bad;
  assign o_pc        = r_pc;

  // A bad current PC is held as the fault record; a bad redirect target is
  // still loaded so the PC shows the offending address.
  always_comb begin
    w_pc_next = r_pc;
    if (i_run && !w_pc_bad) begin
      if (i_redirect_valid) begin
        w_pc_next = i_redirect_pc;
      end else if (!i_stall) begin
        w_pc_next = r_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end for the single-cycle MIPS core.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - ifetch_unit_if.master: stall/redirect in, ROM address/data,
//                registered instruction, its PC and PC+4, valid, sticky fault,
//                delivered-instruction counter
// The PC lives in pc_reg; this level holds the fetch register, FSM and counter.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     ADDR_W    = IMEM_ADDR_W,
  parameter int unsigned     ROM_DEPTH = 77,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  ifetch_unit_if.master bus
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_inst_valid;
  logic            r_fault;
  logic [XLEN-1:0] r_fetch_cnt;

  logic [XLEN-1:0] w_pc;
  logic            w_fault_det;
  logic            w_run;

  assign w_run = (r_state == RUN);

  pc_reg #(
    .ROM_DEPTH (ROM_DEPTH),
    .RESET_PC  (RESET_PC)
  ) u_pc_reg (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_run            (w_run),
    .i_stall          (bus.stall),
    .i_redirect_valid (bus.redirect_valid),
    .i_redirect_pc    (bus.redirect_pc),
    .o_pc             (w_pc),
    .o_fault          (w_fault_det)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_inst       <= NOP;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_fetch_cnt  <= '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_fault_det) begin
            r_state      <= FAULT;
            r_fault      <= 1'b1;
            r_inst_valid <= 1'b0;
          end else if (bus.redirect_valid) begin
            // Word fetched this cycle is wrong-path.
            r_inst_valid <= 1'b0;
          end else if (!bus.stall) begin
            r_inst       <= bus.rom_data;
            r_inst_pc    <= w_pc;
            r_inst_valid <= 1'b1;
            r_fetch_cnt  <= r_fetch_cnt + 32'd1;
          end
        end
        FAULT: begin
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rom_addr   = w_pc[ADDR_W+1:2];
  assign bus.inst       = r_inst;
  assign bus.inst_pc    = r_inst_pc;
  assign bus.inst_pc4   = r_inst_pc + 32'd4;
  assign bus.inst_valid = r_inst_valid;
  assign bus.fault      = r_fault;
  assign bus.fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed + randomized bench for ifetch_unit against a
// behavioural fetch model and a small instruction ROM image.
module tb_ifetch_unit;

  localparam int unsigned     AddrW    = 7;
  localparam int unsigned     RomDepth = 77;
  localparam logic [31:0]     ResetPc  = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rom [128];

  ifetch_unit_if #(.ADDR_W(AddrW)) bus ();

  ifetch_unit #(
    .ADDR_W    (AddrW),
    .ROM_DEPTH (RomDepth),
    .RESET_PC  (ResetPc)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  always #5 clk = ~clk;

  // Behavioural model state.
  logic [31:0] m_pc      = ResetPc;
  logic [31:0] m_inst    = 32'h0;
  logic [31:0] m_inst_pc = 32'h0;
  logic        m_valid   = 1'b0;
  logic        m_fault   = 1'b0;
  logic [31:0] m_cnt     = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one fetch step per edge, straight from the operating rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc      <= ResetPc;
      m_inst    <= 32'h0;
      m_inst_pc <= 32'h0;
      m_valid   <= 1'b0;
      m_fault   <= 1'b0;
      m_cnt     <= 32'h0;
    end else if (!m_fault) begin
      if ((m_pc % 4 != 0) || ((m_pc / 4) >= RomDepth)) begin
        m_fault <= 1'b1;
        m_valid <= 1'b0;
      end else if (bus.redirect_valid && (bus.redirect_pc % 4 != 0)) begin
        m_fault <= 1'b1;
        m_valid <= 1'b0;
        m_pc    <= bus.redirect_pc;
      end else if (bus.redirect_valid) begin
        m_pc    <= bus.redirect_pc;
        m_valid <= 1'b0;
      end else if (!bus.stall) begin
        m_inst    <= rom[(m_pc / 4) % 128];
        m_inst_pc <= m_pc;
        m_valid   <= 1'b1;
        m_pc      <= m_pc + 32'd4;
        m_cnt     <= m_cnt + 32'd1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("inst", bus.inst, m_inst);
    chk("inst_pc", bus.inst_pc, m_inst_pc);
    chk("inst_pc4", bus.inst_pc4, m_inst_pc + 32'd4);
    chk("inst_valid", 32'(bus.inst_valid), 32'(m_valid));
    chk("fault", 32'(bus.fault), 32'(m_fault));
    chk("fetch_cnt", bus.fetch_cnt, m_cnt);
    chk("rom_addr", 32'(bus.rom_addr), (m_pc / 4) % 128);
  end

  task automatic step(input logic st, input logic rv, input logic [31:0] rpc);
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  // Reset pulse between edges; outputs must clear without a clock.
  task automatic rst_pulse();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc4", bus.inst_pc4, 32'h4);
    chk("rst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    chk("rst_cnt", bus.fetch_cnt, 32'h0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned sel;
    sel = $urandom_range(0, 31);
    if (sel == 0) return 32'($urandom_range(0, 76)) * 4 + 32'd2;
    if (sel == 1) return 32'($urandom_range(77, 127)) * 4;
    if (sel == 2) return 32'h1000_0000;
    return 32'($urandom_range(0, 76)) * 4;
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) begin
      rom[i] = (i < int'(RomDepth)) ? (32'h5A00_0000 ^ (32'(i) * 32'h0001_0203)) : 32'h0;
    end
    rom[0]    = 32'h8c150000;
    rom[1]    = 32'h20100004;
    rom[2]    = 32'h20120000;
    rom[3]    = 32'h00125080;
    rom[13]   = 32'h02554822;
    rom[16]   = 32'h8d110000;
    rom[43]   = 32'h0800000d;
    rom[76]   = 32'h8ed1003c;

    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Reset state.
    #3;
    chk("reset_inst", bus.inst, 32'h0);
    chk("reset_inst_pc", bus.inst_pc, 32'h0);
    chk("reset_inst_pc4", bus.inst_pc4, 32'h4);
    chk("reset_valid", 32'(bus.inst_valid), 32'h0);
    chk("reset_fault", 32'(bus.fault), 32'h0);
    chk("reset_cnt", bus.fetch_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line fetch.
    step(1'b0, 1'b0, 32'h0);
    chk("seq0_inst", bus.inst, 32'h8c150000);
    chk("seq0_pc", bus.inst_pc, 32'h0);
    chk("seq0_valid", 32'(bus.inst_valid), 32'h1);
    step(1'b0, 1'b0, 32'h0);
    chk("seq1_inst", bus.inst, 32'h20100004);
    chk("seq1_pc", bus.inst_pc, 32'h4);
    step(1'b0, 1'b0, 32'h0);
    chk("seq2_inst", bus.inst, 32'h20120000);
    chk("seq2_pc", bus.inst_pc, 32'h8);
    chk("seq2_cnt", bus.fetch_cnt, 32'd3);

    // Stall hold.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("stall_inst", bus.inst, 32'h20120000);
      chk("stall_pc", bus.inst_pc, 32'h8);
      chk("stall_valid", 32'(bus.inst_valid), 32'h1);
      chk("stall_cnt", bus.fetch_cnt, 32'd3);
    end
    step(1'b0, 1'b0, 32'h0);
    chk("unstall_inst", bus.inst, 32'h00125080);
    chk("unstall_pc", bus.inst_pc, 32'hC);
    chk("unstall_cnt", bus.fetch_cnt, 32'd4);

    // Redirect during stall.
    step(1'b1, 1'b1, 32'h40);
    chk("rs_bubble", 32'(bus.inst_valid), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("rs_inst", bus.inst, 32'h8d110000);
    chk("rs_pc", bus.inst_pc, 32'h40);
    chk("rs_pc4", bus.inst_pc4, 32'h44);

    // Jump from 0xAC back to 0x34.
    step(1'b0, 1'b1, 32'hAC);
    step(1'b0, 1'b0, 32'h0);
    chk("j_src_inst", bus.inst, 32'h0800000d);
    chk("j_src_pc", bus.inst_pc, 32'hAC);
    step(1'b0, 1'b1, 32'h34);
    chk("j_bubble", 32'(bus.inst_valid), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("j_inst", bus.inst, 32'h02554822);
    chk("j_pc", bus.inst_pc, 32'h34);
    chk("j_valid", 32'(bus.inst_valid), 32'h1);

    // Randomized traffic; faults are cleared by an occasional mid-cycle reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), rand_target());
      if (m_fault && ($urandom_range(0, 7) == 0)) rst_pulse();
    end

    // Misaligned redirect faults and stays faulted.
    rst_pulse();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h42);
    chk("bad_redir_fault", 32'(bus.fault), 32'h1);
    chk("bad_redir_valid", 32'(bus.inst_valid), 32'h0);
    chk("bad_redir_addr", 32'(bus.rom_addr), 32'h10);
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 32'($urandom_range(0, 20)) * 4);
      chk("flt_hold_fault", 32'(bus.fault), 32'h1);
      chk("flt_hold_valid", 32'(bus.inst_valid), 32'h0);
      chk("flt_hold_addr", 32'(bus.rom_addr), 32'h10);
    end

    // Async reset while faulted.
    @(posedge clk);
    #1;
    rst_pulse();
    step(1'b0, 1'b0, 32'h0);
    chk("post_rst_inst", bus.inst, 32'h8c150000);
    chk("post_rst_valid", 32'(bus.inst_valid), 32'h1);
    chk("post_rst_fault", 32'(bus.fault), 32'h0);

    // Sequential run off the end of the populated ROM.
    step(1'b0, 1'b1, 32'h130);
    step(1'b0, 1'b0, 32'h0);
    chk("last_inst", bus.inst, 32'h8ed1003c);
    chk("last_pc", bus.inst_pc, 32'h130);
    chk("last_fault", 32'(bus.fault), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("end_fault", 32'(bus.fault), 32'h1);
    chk("end_valid", 32'(bus.inst_valid), 32'h0);
    chk("end_addr", 32'(bus.rom_addr), 32'd77);
    step(1'b0, 1'b0, 32'h0);
    chk("end_fault_sticky", 32'(bus.fault), 32'h1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench timeout");
  end

endmodule
